// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity-framed serial receiver.
package parity_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int ERR_PARITY = 0;
  localparam int ERR_FRAME  = 1;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/parity_rx_shifter.sv
// LSB-first payload shift register with a running XOR parity accumulator.
module parity_rx_shifter
  import parity_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              acc_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data,
  output logic              parity
);

  // New bits enter at the MSB so the first payload bit ends up at bit 0;
  // the parity bit is folded into the accumulator without shifting.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data   <= '0;
      parity <= 1'b0;
    end else begin
      if (shift_en)
        data <= {bit_in, data[DATA_W-1:1]};
      if (shift_en || acc_en)
        parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start 1, DATA_W bits LSB first, even parity, stop 0.
// Optional statistics counters enabled by PARITY_FRAME_RX_STATS_EN.
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int            BW       = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  rx_state_t         state, state_nxt;
  logic [BW-1:0]     bit_cnt;
  logic              start, shift_en, acc_en, frame_done;
  logic              buf_free, load;
  logic [DATA_W-1:0] sh_data;
  logic              sh_parity;
  logic [1:0]        frame_err;

  parity_rx_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .shift_en (shift_en),
    .acc_en   (acc_en),
    .bit_in   (in_bit),
    .data     (sh_data),
    .parity   (sh_parity)
  );

  // Idle samples (in_valid=0) leave every state untouched.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    acc_en     = 1'b0;
    frame_done = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (in_bit) begin
            start     = 1'b1;
            state_nxt = DATA;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT)
            state_nxt = PARITY;
        end
        PARITY: begin
          acc_en    = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_err             = 2'b00;
    frame_err[ERR_PARITY] = sh_parity;
    frame_err[ERR_FRAME]  = in_bit;
  end

  assign buf_free = !out_valid || out_ready;
  assign load     = frame_done && buf_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start)
        bit_cnt <= '0;
      else if (shift_en)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Single-entry holding buffer; a load wins over a simultaneous pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= sh_data;
        out_err   <= frame_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (frame_done && !buf_free)
        overflow <= 1'b1;
    end
  end

`ifdef PARITY_FRAME_RX_STATS_EN
  // Dropped frames still count: statistics reflect the line, not the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 1'b1;
      if (|frame_err)
        err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx with a one-deep scoreboard model.
module tb_parity_frame_rx;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_bit;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_err;
  logic              out_valid;
  logic              overflow;
  logic [15:0]       frame_cnt;
  logic [15:0]       err_cnt;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       stop;
    int         gap;
    logic [1:0] exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  logic started = 1'b0;
  logic stop_pending = 1'b0;
  exp_t pending_exp;
  logic model_ovf = 1'b0;
  int   model_frames = 0;
  int   model_errs = 0;
  logic expect_zero = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model compares against the state after the previous edge, then advances to the next edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        checkOutput("out_data", {24'b0, out_data}, {24'b0, exp_q[0].data});
        checkOutput("out_err", {30'b0, out_err}, {30'b0, exp_q[0].err});
      end else if (expect_zero) begin
        checkOutput("out_data_zero", {24'b0, out_data}, 32'd0);
        checkOutput("out_err_zero", {30'b0, out_err}, 32'd0);
      end
      checkOutput("overflow", {31'b0, overflow}, {31'b0, model_ovf});
`ifdef PARITY_FRAME_RX_STATS_EN
      checkOutput("frame_cnt", {16'b0, frame_cnt}, {16'b0, model_frames[15:0]});
      checkOutput("err_cnt", {16'b0, err_cnt}, {16'b0, model_errs[15:0]});
`else
      checkOutput("frame_cnt", {16'b0, frame_cnt}, 32'd0);
      checkOutput("err_cnt", {16'b0, err_cnt}, 32'd0);
`endif
      if (reset) begin
        exp_q.delete();
        model_ovf    = 1'b0;
        model_frames = 0;
        model_errs   = 0;
        expect_zero  = 1'b1;
      end else begin
        if (exp_q.size() != 0 && out_ready)
          void'(exp_q.pop_front());
        if (stop_pending) begin
          model_frames++;
          if (pending_exp.err != 2'b00)
            model_errs++;
          if (exp_q.size() == 0) begin
            exp_q.push_back(pending_exp);
            expect_zero = 1'b0;
          end else begin
            model_ovf = 1'b1;
          end
        end
      end
    end
  end

  task automatic driveBit(input logic b, input logic is_stop);
    @(posedge clk);
    #1;
    in_valid     = 1'b1;
    in_bit       = b;
    stop_pending = is_stop;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_bit       = 1'($urandom_range(0, 1));
    stop_pending = 1'b0;
  endtask

  task automatic gapCycles(input int gap);
    int n;
    n = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
    for (int k = 0; k < n; k++)
      idleCycle();
  endtask

  task automatic applyStimulus(input vec_t v, input logic raise_ready);
    logic [7:0] d;
    logic       par;
    d   = v.data;
    par = (^d) ^ v.flip;
    driveBit(1'b1, 1'b0);
    gapCycles(v.gap);
    for (int k = 0; k < DATA_W; k++) begin
      driveBit(d[k], 1'b0);
      gapCycles(v.gap);
    end
    driveBit(par, 1'b0);
    gapCycles(v.gap);
    pending_exp.data = v.data;
    pending_exp.err  = v.exp_err;
    driveBit(v.stop, 1'b1);
    if (raise_ready)
      out_ready = 1'b1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset        = 1'b1;
    in_valid     = 1'b0;
    stop_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 0, 2'b00};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 0, 2'b01};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 0, 2'b10};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 0, 2'b00};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 2'b11};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 2, 2'b00};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 1, 2'b00};

    @(posedge clk);
    #1;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idleCycle();

    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i], 1'b0);
    repeat (3) idleCycle();

    $display("[TB] backpressure: second frame dropped");
    doReset();
    out_ready = 1'b0;
    v = '{8'h11, 1'b0, 1'b0, 0, 2'b00};
    applyStimulus(v, 1'b0);
    v = '{8'h22, 1'b0, 1'b0, 0, 2'b00};
    applyStimulus(v, 1'b0);
    idleCycle();
    idleCycle();
    @(negedge clk);
    checkOutput("held_data", {24'b0, out_data}, 32'h11);
    checkOutput("held_ovf", {31'b0, overflow}, 32'd1);
`ifdef PARITY_FRAME_RX_STATS_EN
    checkOutput("held_frames", {16'b0, frame_cnt}, 32'd2);
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) idleCycle();

    $display("[TB] simultaneous pop and load");
    doReset();
    out_ready = 1'b0;
    v = '{8'h11, 1'b0, 1'b0, 0, 2'b00};
    applyStimulus(v, 1'b0);
    v = '{8'h22, 1'b0, 1'b0, 0, 2'b00};
    applyStimulus(v, 1'b1);
    idleCycle();
    @(negedge clk);
    checkOutput("swap_data", {24'b0, out_data}, 32'h22);
    checkOutput("swap_ovf", {31'b0, overflow}, 32'd0);
    repeat (3) idleCycle();

    $display("[TB] reset mid-frame then gapped frame");
    driveBit(1'b1, 1'b0);
    driveBit(1'b1, 1'b0);
    driveBit(1'b0, 1'b0);
    driveBit(1'b1, 1'b0);
    driveBit(1'b1, 1'b0);
    doReset();
    v = '{8'h7E, 1'b0, 1'b0, 2, 2'b00};
    applyStimulus(v, 1'b0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      idleCycle();
    repeat (2) idleCycle();
    checkOutput("drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
